// File: rtl/loader_pkg.sv
// Shared constants and state types for uart_mem_loader and its frame parser.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package loader_pkg;

  localparam logic [7:0] START_BYTE  = 8'hF5;
  localparam logic [7:0] STOP_BYTE   = 8'hFA;
  localparam logic [7:0] DUMP_BYTE   = 8'hF6;
  localparam int         ADDR_W      = 10;
  localparam int         DATA_W      = 12;
  localparam logic [2:0] PAYLOAD_LEN = 3'd4;

  typedef enum logic [1:0] {IDLE, PAYLOAD, ERR} parse_state_t;

  typedef enum logic [2:0] {W_IDLE, ADDR_L, DATA_L, ADDR_U, DATA_U, CLEAR} wr_state_t;

  // 8-bit increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/loader_frame_parser.sv
// Parses F5 <4 payload> FA host frames into one (addr, data) write command; flags F6 dump requests.
// Latency: commit is combinational with the STOP strobe; dump_req is registered one cycle after F6.
// Backpressure: none; a commit raised while the writer is busy is dropped by the top and counted here.
module loader_frame_parser
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              wr_busy,
  output logic              commit,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              dump_req,
  output logic [7:0]        err_count
);

  parse_state_t state, state_n;
  logic [2:0]   cnt, cnt_n;
  logic [4:0]   sh0, sh1;
  logic [5:0]   sh2, sh3;
  logic         is_start, is_stop, is_dump, is_pay;
  logic         store, frm_err;

  assign is_start = (rx_data == START_BYTE);
  assign is_stop  = (rx_data == STOP_BYTE);
  assign is_dump  = (rx_data == DUMP_BYTE);
  assign is_pay   = rx_valid && !is_start && !is_stop && !is_dump;

  // A complete frame commits on its STOP byte, in the same cycle
  assign commit = rx_valid && is_stop && (state == PAYLOAD) && (cnt == PAYLOAD_LEN);

  // Parser state and payload index register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: only valid bytes move the parser, and a dump byte never does.
  // A stray STOP while IDLE is not inside any frame and is ignored.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (rx_valid && !is_dump) begin
      if (is_start) begin
        state_n = PAYLOAD;
        cnt_n   = '0;
      end else if (is_stop) begin
        state_n = IDLE;
      end else if (state == PAYLOAD) begin
        if (cnt == PAYLOAD_LEN) state_n = ERR;
        else                    cnt_n   = cnt + 3'd1;
      end
    end
  end

  // Outputs: shadow write enable, framing error, and the field mapping
  always_comb begin
    store   = is_pay && (state == PAYLOAD) && (cnt != PAYLOAD_LEN);
    frm_err = (rx_valid && is_stop &&
               ((state == ERR) || ((state == PAYLOAD) && (cnt != PAYLOAD_LEN)))) ||
              (is_pay && (state == PAYLOAD) && (cnt == PAYLOAD_LEN));
    addr    = {sh0, sh1};
    data    = {sh2, sh3};
  end

  // Shadow capture; only the bits the field mapping uses are kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh0 <= '0;
      sh1 <= '0;
      sh2 <= '0;
      sh3 <= '0;
    end else if (store) begin
      case (cnt[1:0])
        2'd0:    sh0 <= rx_data[4:0];
        2'd1:    sh1 <= rx_data[4:0];
        2'd2:    sh2 <= rx_data[5:0];
        default: sh3 <= rx_data[5:0];
      endcase
    end
  end

  // Error counter (framing and overrun) and the one-cycle dump pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      dump_req  <= 1'b0;
    end else begin
      if (frm_err || (commit && wr_busy)) err_count <= sat_inc8(err_count);
      dump_req <= rx_valid && is_dump;
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// UART frame loader: turns parsed host frames into 4-cycle memory_fpga writes, CPU passthrough when idle.
// Latency: first bus cycle 1 cycle after the STOP strobe, 4 bus cycles; passthrough is combinational.
// Backpressure: none; a frame completing while the writer is busy is dropped as overrun. Option: LOADER_CLEAR_EN.
module uart_mem_loader
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [ADDR_W-1:0] cpu_addr_data,
  input  logic              cpu_read_write,
  input  logic              cpu_write_commit,
  output logic [ADDR_W-1:0] mem_addr_data,
  output logic              mem_read_write,
  output logic              mem_write_commit,
  output logic              dump_req,
  output logic              loader_busy,
  output logic [7:0]        frame_count,
  output logic [7:0]        err_count
);

  wr_state_t         state, state_n;
  logic              cmd_vld, wr_busy, accept;
  logic [ADDR_W-1:0] cmd_addr, wr_addr;
  logic [DATA_W-1:0] cmd_data, wr_data;

`ifdef LOADER_CLEAR_EN
  logic        boot;
  logic [1:0]  clr_phase;
  logic [10:0] clr_addr;
  // The first cycle after reset is reserved for entering CLEAR
  assign wr_busy = (state != W_IDLE) || boot;
`else
  assign wr_busy = (state != W_IDLE);
`endif
  assign accept = cmd_vld && !wr_busy;

  loader_frame_parser u_parser (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .wr_busy   (wr_busy),
    .commit    (cmd_vld),
    .addr      (cmd_addr),
    .data      (cmd_data),
    .dump_req  (dump_req),
    .err_count (err_count)
  );

  // Writer state register; loader_busy is registered from the next state so it tracks the bus owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= W_IDLE;
      loader_busy <= 1'b0;
    end else begin
      state       <= state_n;
      loader_busy <= (state_n != W_IDLE);
    end
  end

  // Capture an accepted command and count it as a good frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_count <= '0;
    end else if (accept) begin
      wr_addr     <= cmd_addr;
      wr_data     <= cmd_data;
      frame_count <= frame_count + 8'd1;
    end
  end

`ifdef LOADER_CLEAR_EN
  // Clear sweep: phase walks the 4-beat write, address advances after each commit beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      boot      <= 1'b1;
      clr_phase <= '0;
      clr_addr  <= '0;
    end else begin
      boot <= 1'b0;
      if (state == CLEAR) begin
        clr_phase <= clr_phase + 2'd1;
        if (clr_phase == 2'd3) clr_addr <= clr_addr + 11'd1;
      end
    end
  end
`endif

  // Writer next state: fixed four-beat sequence per accepted command
  always_comb begin
    state_n = state;
    case (state)
`ifdef LOADER_CLEAR_EN
      W_IDLE: if (boot) state_n = CLEAR;
              else if (accept) state_n = ADDR_L;
      CLEAR:  if ((clr_phase == 2'd3) && (clr_addr == 11'd1023)) state_n = W_IDLE;
`else
      W_IDLE: if (accept) state_n = ADDR_L;
`endif
      ADDR_L:  state_n = DATA_L;
      DATA_L:  state_n = ADDR_U;
      ADDR_U:  state_n = DATA_U;
      DATA_U:  state_n = W_IDLE;
      default: state_n = W_IDLE;
    endcase
  end

  // Bus mux: loader beats while writing, CPU passthrough otherwise
  always_comb begin
    mem_addr_data    = wr_addr;
    mem_read_write   = 1'b1;
    mem_write_commit = 1'b0;
    case (state)
      ADDR_L, ADDR_U: ;
      DATA_L: mem_addr_data = {{(ADDR_W-6){1'b0}}, wr_data[5:0]};
      DATA_U: begin
        mem_addr_data    = {{(ADDR_W-6){1'b0}}, wr_data[11:6]};
        mem_write_commit = 1'b1;
      end
`ifdef LOADER_CLEAR_EN
      CLEAR: begin
        mem_addr_data    = clr_phase[0] ? '0 : clr_addr[ADDR_W-1:0];
        mem_write_commit = (clr_phase == 2'd3);
      end
`endif
      default: begin
        mem_addr_data    = cpu_addr_data;
        mem_read_write   = cpu_read_write;
        mem_write_commit = cpu_write_commit;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Randomized bench for uart_mem_loader against a frame-level reference model.
// Latency: model expects the first bus beat one cycle after the STOP strobe.
// Backpressure: overrun is provoked by forcing the parser commit while a write is in flight.
module tb_uart_mem_loader;

  localparam logic [7:0] B_START = 8'hF5;
  localparam logic [7:0] B_STOP  = 8'hFA;
  localparam logic [7:0] B_DUMP  = 8'hF6;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [9:0] cpu_addr_data;
  logic       cpu_read_write, cpu_write_commit;
  logic [9:0] mem_addr_data;
  logic       mem_read_write, mem_write_commit;
  logic       dump_req, loader_busy;
  logic [7:0] frame_count, err_count;

  uart_mem_loader dut (
    .clk              (clk),
    .rst              (rst),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .cpu_addr_data    (cpu_addr_data),
    .cpu_read_write   (cpu_read_write),
    .cpu_write_commit (cpu_write_commit),
    .mem_addr_data    (mem_addr_data),
    .mem_read_write   (mem_read_write),
    .mem_write_commit (mem_write_commit),
    .dump_req         (dump_req),
    .loader_busy      (loader_busy),
    .frame_count      (frame_count),
    .err_count        (err_count)
  );

  always #20 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  typedef struct packed {
    logic [9:0] ad;
    logic       rw;
    logic       cm;
  } beat_t;

  beat_t      beats[$];
  logic [7:0] pq[$];
  logic [9:0] seen[$];
  bit         in_frame, err_mode, last_beat, m_dump;
  logic [7:0] m_frames, m_err;
  int         dump_hits;

  task automatic m_reset();
    beats.delete(); pq.delete();
    in_frame = 0; err_mode = 0; last_beat = 0; m_dump = 0;
    m_frames = 0; m_err = 0;
  endtask

  task automatic m_err_inc();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  // A finished frame is written only if the bus was free in the cycle it completed
  task automatic m_commit();
    logic [9:0]  a;
    logic [11:0] d;
    if (last_beat) begin
      m_err_inc();
    end else begin
      a = {pq[0][4:0], pq[1][4:0]};
      d = {pq[2][5:0], pq[3][5:0]};
      beats.push_back('{ad: a, rw: 1'b1, cm: 1'b0});
      beats.push_back('{ad: {4'b0, d[5:0]}, rw: 1'b1, cm: 1'b0});
      beats.push_back('{ad: a, rw: 1'b1, cm: 1'b0});
      beats.push_back('{ad: {4'b0, d[11:6]}, rw: 1'b1, cm: 1'b1});
      m_frames = m_frames + 8'd1;
    end
  endtask

  task automatic model(input logic v, input logic [7:0] b, input bit frc);
    m_dump = v && (b == B_DUMP);
    if (v && (b != B_DUMP)) begin
      if (b == B_START) begin
        in_frame = 1; err_mode = 0; pq.delete();
      end else if (b == B_STOP) begin
        if (in_frame && pq.size() == 4) m_commit();
        else if (in_frame || err_mode)  m_err_inc();
        in_frame = 0; err_mode = 0;
      end else if (in_frame) begin
        if (pq.size() == 4) begin
          m_err_inc(); in_frame = 0; err_mode = 1;
        end else begin
          pq.push_back(b);
        end
      end
    end
    if (frc) m_commit();
  endtask

  // One clock: drive, let the edge pass, update the model, compare 1 time unit later
  task automatic step(input logic v, input logic [7:0] b, input bit frc);
    beat_t e;
    rx_valid         = v;
    rx_data          = b;
    cpu_addr_data    = 10'($urandom);
    cpu_read_write   = 1'($urandom);
    cpu_write_commit = 1'($urandom);
    if (frc) force dut.u_parser.commit = 1'b1;
    @(posedge clk);
    model(v, b, frc);
    #1;
    if (frc) release dut.u_parser.commit;
    if (beats.size() > 0) begin
      e = beats.pop_front();
      last_beat = 1;
      seen.push_back(mem_addr_data);
      check("bus_addr",   32'(mem_addr_data),    32'(e.ad));
      check("bus_rw",     32'(mem_read_write),   32'(e.rw));
      check("bus_commit", 32'(mem_write_commit), 32'(e.cm));
      check("busy_write", 32'(loader_busy),      32'd1);
    end else begin
      last_beat = 0;
      check("pass_addr",   32'(mem_addr_data),    32'(cpu_addr_data));
      check("pass_rw",     32'(mem_read_write),   32'(cpu_read_write));
      check("pass_commit", 32'(mem_write_commit), 32'(cpu_write_commit));
      check("busy_idle",   32'(loader_busy),      32'd0);
    end
    if (dump_req) dump_hits++;
    check("dump_req",    32'(dump_req),    32'(m_dump));
    check("frame_count", 32'(frame_count), 32'(m_frames));
    check("err_count",   32'(err_count),   32'(m_err));
  endtask

  function automatic logic [7:0] rnd_pay();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == B_START || b == B_STOP || b == B_DUMP) b = b & 8'h7F;
    return b;
  endfunction

  task automatic send(input logic [7:0] b);
    if ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), 1'b0);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic good_frame();
    step(1'b1, B_START, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, rnd_pay(), 1'b0);
    step(1'b1, B_STOP, 1'b0);
  endtask

  task automatic rand_segment();
    int k;
    k = $urandom_range(0, 5);
    case (k)
      0: begin
        send(B_START);
        for (int i = 0; i < 4; i++) send(rnd_pay());
        send(B_STOP);
      end
      1: begin
        send(B_START);
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) send(rnd_pay());
        send(B_STOP);
      end
      2: begin
        send(B_START);
        for (int i = 0; i < int'($urandom_range(5, 6)); i++) send(rnd_pay());
        send(B_STOP);
      end
      3: send(B_DUMP);
      4: for (int i = 0; i < int'($urandom_range(1, 3)); i++) send(rnd_pay());
      default: begin
        send(B_START);
        send(rnd_pay()); send(rnd_pay()); send(B_DUMP);
        send(rnd_pay()); send(rnd_pay());
        send(B_STOP);
      end
    endcase
  endtask

  logic [7:0] f0, e0;
  logic [9:0] exp_seen [4];

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    cpu_addr_data = '0; cpu_read_write = 1'b0; cpu_write_commit = 1'b0;
    m_reset();
    dump_hits = 0;
    #30;
    check("rst_mem_addr",   32'(mem_addr_data),    32'd0);
    check("rst_mem_rw",     32'(mem_read_write),   32'd0);
    check("rst_mem_commit", 32'(mem_write_commit), 32'd0);
    check("rst_dump",       32'(dump_req),         32'd0);
    check("rst_busy",       32'(loader_busy),      32'd0);
    check("rst_frames",     32'(frame_count),      32'd0);
    check("rst_errs",       32'(err_count),        32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Known frame with hand-derived bus beats
    seen.delete();
    step(1'b1, B_START, 1'b0);
    step(1'b1, 8'h03, 1'b0); step(1'b1, 8'h1F, 1'b0);
    step(1'b1, 8'h2A, 1'b0); step(1'b1, 8'h15, 1'b0);
    step(1'b1, B_STOP, 1'b0);
    idle(5);
    exp_seen = '{10'h07F, 10'h015, 10'h07F, 10'h02A};
    check("known_beats", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++) check("known_beat", 32'(seen[i]), 32'(exp_seen[i]));
    check("known_frames", 32'(frame_count), 32'd1);

    // Short frame: no bus activity, one error, then a good frame writes
    seen.delete();
    step(1'b1, B_START, 1'b0); step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);   step(1'b1, B_STOP, 1'b0);
    idle(5);
    check("short_no_bus", 32'(seen.size()), 32'd0);
    check("short_errs",   32'(err_count),   32'd1);
    good_frame();
    idle(5);

    // Dump byte inside a frame
    dump_hits = 0;
    step(1'b1, B_START, 1'b0); step(1'b1, rnd_pay(), 1'b0);
    step(1'b1, B_DUMP, 1'b0);
    step(1'b1, rnd_pay(), 1'b0); step(1'b1, rnd_pay(), 1'b0); step(1'b1, rnd_pay(), 1'b0);
    step(1'b1, B_STOP, 1'b0);
    idle(5);
    check("dump_pulses", 32'(dump_hits), 32'd1);

    // Second commit two cycles after the first STOP is an overrun
    f0 = m_frames; e0 = m_err;
    good_frame();
    idle(1);
    step(1'b0, 8'h00, 1'b1);
    idle(4);
    check("overrun_frames", 32'(frame_count), 32'(f0 + 8'd1));
    check("overrun_errs",   32'(err_count),   32'(e0 + 8'd1));

    // Reset while the writer shows DATA_L
    good_frame();
    idle(1);
    cpu_addr_data = 10'($urandom); cpu_read_write = 1'($urandom); cpu_write_commit = 1'($urandom);
    rst = 1'b1;
    #1;
    check("midrst_addr",   32'(mem_addr_data),    32'(cpu_addr_data));
    check("midrst_rw",     32'(mem_read_write),   32'(cpu_read_write));
    check("midrst_commit", 32'(mem_write_commit), 32'(cpu_write_commit));
    check("midrst_busy",   32'(loader_busy),      32'd0);
    check("midrst_frames", 32'(frame_count),      32'd0);
    check("midrst_errs",   32'(err_count),        32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Randomized traffic
    for (int s = 0; s < 300; s++) rand_segment();
    idle(6);

    // Error counter saturates
    for (int i = 0; i < 260; i++) begin
      step(1'b1, B_START, 1'b0);
      step(1'b1, B_STOP, 1'b0);
    end
    check("err_saturate", 32'(err_count), 32'd255);

    // Frame counter wraps after 256 good frames
    f0 = m_frames;
    for (int i = 0; i < 256; i++) good_frame();
    idle(6);
    check("frame_wrap", 32'(frame_count), 32'(f0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Sits between uart_rx and memory_fpga: parses framed host bytes into (address, data) write commands.
- Drives the 10-bit memory bus with the multi-cycle write sequence; passes CPU bus signals through when idle.
- Emits a one-cycle dump request on the read-out command byte.
- Replaces ad-hoc frame capture in the FPGA top level.

Parameters:
- START_BYTE, 8'hF5, frame start marker
- STOP_BYTE, 8'hFA, frame stop / commit marker
- DUMP_BYTE, 8'hF6, memory read-out command
- ADDR_W, 10, memory address / bus width
- DATA_W, 12, memory word width (two 6-bit halves)

Ports:
- clk  in  1  system clock (25 MHz)
- rst  in  1  asynchronous reset, active-high
- rx_data  in  8  byte from uart_rx
- rx_valid  in  1  one-cycle strobe, rx_data valid
- cpu_addr_data  in  10  CPU bus
- cpu_read_write  in  1  CPU bus
- cpu_write_commit  in  1  CPU bus
- mem_addr_data  out  10  to memory_fpga
- mem_read_write  out  1  to memory_fpga
- mem_write_commit  out  1  to memory_fpga
- dump_req  out  1  one-cycle pulse, start memory read-out
- loader_busy  out  1  high while loader owns the memory bus; doubles as CPU hold
- frame_count  out  8  good frames written, wraps 255->0
- err_count  out  8  framing/overrun errors, saturates at 255

Behaviour:
- Reset values: all outputs 0; mem_* = 0; parser IDLE; writer W_IDLE; shadow and commit registers 0.
- Parser FSM, evaluated only on rx_valid:
  - Parser states: IDLE, PAYLOAD(n = 0..4), ERR.
  - DUMP_BYTE in any state: dump_req = 1 the next cycle; parser state unchanged.
  - START_BYTE in any state: go to PAYLOAD, n = 0.
  - Other bytes in PAYLOAD with n < 4: store to shadow[n], n++.
  - Fifth payload byte: ERR, err_count++.
  - STOP_BYTE with n == 4: commit, IDLE.
  - STOP_BYTE with n != 4, or in ERR: err_count++, IDLE.
  - Payload bytes in IDLE or ERR: ignored.
- Field mapping:
  - addr = {shadow0[4:0], shadow1[4:0]}; data = {shadow2[5:0], shadow3[5:0]}.
  - Unused upper bits are ignored, not checked.
- Commit:
  - If writer is W_IDLE: copy addr/data into write registers; writer starts the next cycle; frame_count++.
  - If writer is busy: frame dropped; err_count++ (overrun).
- Writer FSM:
  - Sequence: W_IDLE -> ADDR_L -> DATA_L -> ADDR_U -> DATA_U -> W_IDLE; one cycle per state.
  - ADDR_L, ADDR_U: mem_addr_data = addr; rw = 1; commit = 0.
  - DATA_L: mem_addr_data = {4'b0, data[5:0]}; rw = 1; commit = 0.
  - DATA_U: mem_addr_data = {4'b0, data[11:6]}; rw = 1; commit = 1.
  - Write latency: first bus cycle is 1 cycle after the STOP strobe; 4 bus cycles total.
- Bus mux:
  - In W_IDLE, mem_* = cpu_* combinationally (zero latency).
  - loader_busy = (writer != W_IDLE), registered.
- Simultaneous events: rx_valid during a write is parsed normally; only commits collide.
- rst mid-write: bus returns to passthrough immediately; the partial write is abandoned; counters cleared.

Optional Feature:
- LOADER_CLEAR_EN defined:
  - After reset release, state CLEAR writes 0 to addresses 0..1023 using the same 4-cycle sequence (4096 cycles).
  - loader_busy = 1 throughout CLEAR.
  - A commit during CLEAR counts as overrun.
  - Address counter is 11 bits; CLEAR ends when it reaches 1024.
- Undefined: no CLEAR state; writer is W_IDLE right after reset.

Decomposition:
- Package loader_pkg holds:
  - START_BYTE, STOP_BYTE, DUMP_BYTE localparams.
  - Enum parse_state_t {IDLE, PAYLOAD, ERR}.
  - Enum wr_state_t {W_IDLE, ADDR_L, DATA_L, ADDR_U, DATA_U, CLEAR}.
- Sub-module loader_frame_parser: parser FSM, shadow registers, err_count; outputs a commit strobe with addr/data.
- Writer and bus mux stay in the top module.

Test Plan:
- F5 03 1F 2A 15 FA -> addr 0x07F, data 0xA95; 4 bus cycles: 07F, 015, 07F, 02A; commit only on the 4th; frame_count = 1.
- F5 01 02 FA -> no bus activity; err_count = 1; then a valid frame writes correctly.
- F6 between two payload bytes -> dump_req pulses exactly 1 cycle; the frame still writes.
- Two STOP-complete frames forced 2 cycles apart -> second dropped; err_count = 1; frame_count = 1.
- Assert rst during DATA_L -> mem_* immediately equal cpu_*; loader_busy = 0; counters 0.
- LOADER_CLEAR_EN: after reset, 1024 commit pulses with data halves 0; loader_busy high for 4096 cycles.
